// File: rtl/aes_pkg.sv
// Shared definitions for the AES round sequencer: state encoding, round modes,
// key-length codes, default round counts and the registered control bundle.
package aes_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_INIT  = 2'b11;
  localparam logic [1:0] MODE_ROUND = 2'b00;
  localparam logic [1:0] MODE_FINAL = 2'b10;

  localparam logic [1:0] KEYLEN_128 = 2'b00;
  localparam logic [1:0] KEYLEN_192 = 2'b01;
  localparam logic [1:0] KEYLEN_256 = 2'b10;
  localparam logic [1:0] KEYLEN_BAD = 2'b11;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  // Single-bit controls plus mode; round_idx is kept apart since its width is a parameter.
  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       d_en;
    logic       k_en;
    logic       key_sel;
    logic       core_reset;
    logic [1:0] mode;
    logic       done;
    logic       err;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{ready: 1'b1, busy: 1'b0, d_en: 1'b0, k_en: 1'b0,
                                key_sel: 1'b0, core_reset: 1'b1, mode: MODE_INIT,
                                done: 1'b0, err: 1'b0};
  localparam ctl_t CTL_BUSY = '{ready: 1'b0, busy: 1'b1, d_en: 1'b0, k_en: 1'b0,
                                key_sel: 1'b0, core_reset: 1'b0, mode: MODE_ROUND,
                                done: 1'b0, err: 1'b0};

endpackage

// File: rtl/aes_round_ctrl.sv
// AES-128/192/256 round sequencer, encrypt or decrypt, one round per clock.
// Every output is a flop; next values are computed alongside the next state.
module aes_round_ctrl #(
  parameter int NR_128 = aes_pkg::NR_128,
  parameter int NR_192 = aes_pkg::NR_192,
  parameter int NR_256 = aes_pkg::NR_256,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic             decrypt,
  input  logic             stall,
  output logic             ready,
  output logic             busy,
  output logic             d_en,
  output logic             k_en,
  output logic             key_sel,
  output logic             core_reset,
  output logic [1:0]       mode,
  output logic [IDX_W-1:0] round_idx,
  output logic             done,
  output logic             err
);
  import aes_pkg::*;

  if (NR_256 > (2**IDX_W) - 1 || NR_192 > (2**IDX_W) - 1 || NR_128 > (2**IDX_W) - 1) begin : g_idx_chk
    $error("aes_round_ctrl: IDX_W too narrow for round count");
  end

  function automatic logic [IDX_W-1:0] nr_of(input logic [1:0] kl);
    case (kl)
      KEYLEN_192: nr_of = IDX_W'(NR_192);
      KEYLEN_256: nr_of = IDX_W'(NR_256);
      default:    nr_of = IDX_W'(NR_128);
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       kl_q, kl_d;
  logic             dec_q, dec_d;
  ctl_t             ctl_q, ctl_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] nr_q;
  logic             long_key;
  logic             last_round;

  assign nr_q       = nr_of(kl_q);
  assign long_key   = (kl_q != KEYLEN_128);
  assign last_round = dec_q ? (idx_q == IDX_W'(1)) : (idx_q == nr_q - IDX_W'(1));

  always_comb begin
    state_d = state_q;
    kl_d    = kl_q;
    dec_d   = dec_q;
    ctl_d   = ctl_q;
    idx_d   = idx_q;
    // stall leaves every register untouched, so a frozen done still reads as one pulse
    if (!stall) begin
      ctl_d = CTL_BUSY;
      case (state_q)
        S_IDLE: begin
          ctl_d = CTL_IDLE;
          idx_d = '0;
          if (start && key_len == KEYLEN_BAD) begin
            ctl_d.err = 1'b1;
          end else if (start) begin
            state_d       = S_INIT;
            kl_d          = key_len;
            dec_d         = decrypt;
            ctl_d         = CTL_BUSY;
            ctl_d.d_en    = 1'b1;
            ctl_d.k_en    = 1'b1;
            ctl_d.key_sel = (key_len != KEYLEN_128);
            ctl_d.mode    = MODE_INIT;
            idx_d         = decrypt ? nr_of(key_len) : '0;
          end
        end
        S_INIT: begin
          // 192/256 load the upper key half on the first full round
          state_d       = S_ROUND;
          ctl_d.k_en    = long_key;
          ctl_d.key_sel = long_key;
          idx_d         = dec_q ? nr_q - IDX_W'(1) : IDX_W'(1);
        end
        S_ROUND: begin
          if (last_round) begin
            state_d    = S_FINAL;
            ctl_d.mode = MODE_FINAL;
            idx_d      = dec_q ? '0 : nr_q;
          end else begin
            idx_d = dec_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
          end
        end
        S_FINAL: begin
          state_d    = S_DONE;
          ctl_d.done = 1'b1;
          ctl_d.mode = MODE_INIT;
        end
        S_DONE: begin
          state_d = S_IDLE;
          ctl_d   = CTL_IDLE;
          idx_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          ctl_d   = CTL_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      kl_q    <= KEYLEN_128;
      dec_q   <= 1'b0;
      ctl_q   <= CTL_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      kl_q    <= kl_d;
      dec_q   <= dec_d;
      ctl_q   <= ctl_d;
      idx_q   <= idx_d;
    end
  end

  assign ready      = ctl_q.ready;
  assign busy       = ctl_q.busy;
  assign d_en       = ctl_q.d_en;
  assign k_en       = ctl_q.k_en;
  assign key_sel    = ctl_q.key_sel;
  assign core_reset = ctl_q.core_reset;
  assign mode       = ctl_q.mode;
  assign round_idx  = idx_q;
  assign done       = ctl_q.done;
  assign err        = ctl_q.err;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: an operation-position model checked every cycle,
// plus directed runs with hand-computed latencies and round-index samples.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] key_len = 2'b00;
  logic       decrypt = 1'b0;
  logic       stall = 1'b0;
  logic       ready, busy, d_en, k_en, key_sel, core_reset, done, err;
  logic [1:0] mode;
  logic [3:0] round_idx;

  aes_round_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key_len(key_len), .decrypt(decrypt),
    .stall(stall), .ready(ready), .busy(busy), .d_en(d_en), .k_en(k_en), .key_sel(key_sel),
    .core_reset(core_reset), .mode(mode), .round_idx(round_idx), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int nr(input int kl);
    return (kl == 1) ? 12 : (kl == 2) ? 14 : 10;
  endfunction

  // Model: position k within an operation (0=INIT .. Nr+1=DONE), frozen by stall.
  bit m_act, m_err, m_dec;
  int m_k, m_kl;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act <= 0; m_err <= 0; m_k <= 0; m_kl <= 0; m_dec <= 0;
    end else if (!stall) begin
      m_err <= 0;
      if (m_act) begin
        if (m_k == nr(m_kl) + 1) m_act <= 0;
        else m_k <= m_k + 1;
      end else if (start) begin
        if (key_len == 2'b11) m_err <= 1;
        else begin
          m_act <= 1; m_k <= 0; m_kl <= int'(key_len); m_dec <= decrypt;
        end
      end
    end
  end

  function automatic logic [13:0] exp_vec();
    int n, ix;
    logic [1:0] md;
    if (!m_act) return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 4'd0, 1'b0, m_err};
    n  = nr(m_kl);
    ix = (m_k <= n) ? (m_dec ? n - m_k : m_k) : (m_dec ? 0 : n);
    md = (m_k == 0 || m_k == n + 1) ? 2'b11 : (m_k == n) ? 2'b10 : 2'b00;
    return {1'b0, 1'b1, m_k == 0, (m_k == 0) || (m_k == 1 && m_kl != 0),
            (m_kl != 0) && (m_k <= 1), 1'b0, md, 4'(ix), m_k == n + 1, 1'b0};
  endfunction

  wire [13:0] dut_vec = {ready, busy, d_en, k_en, key_sel, core_reset, mode, round_idx, done, err};
  localparam logic [13:0] RST_VEC = 14'b10000111000000;

  always @(negedge clk) if (reset_n) chk("cycle_vs_model", 32'(dut_vec), 32'(exp_vec()));

  logic [3:0] idx_log[$];
  logic       ksel_log[$];

  task automatic run_op(input logic [1:0] kl, input bit dec, input int stall_idx,
                        input bit hold, output int lat);
    int a;
    bit did = 0;
    idx_log.delete(); ksel_log.delete();
    @(negedge clk); key_len = kl; decrypt = dec; start = 1'b1;
    @(posedge clk); #1; a = cyc;
    if (!hold) start = 1'b0;
    key_len = ~kl; decrypt = ~dec;  // post-accept changes must not matter
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      idx_log.push_back(round_idx); ksel_log.push_back(key_sel);
      if (done) begin lat = cyc - a + 1; break; end
      if (stall_idx != 0 && !did && mode == 2'b00 && int'(round_idx) == stall_idx) begin
        did = 1; stall = 1'b1;
        repeat (3) begin @(negedge clk); chk("stall_idx_frozen", 32'(round_idx), 32'(stall_idx)); end
        stall = 1'b0;
      end
    end
    key_len = kl; decrypt = dec;
  endtask

  initial begin
    int lat;
    #12;
    chk("reset_vec", 32'(dut_vec), 32'(RST_VEC));
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    // AES-128 encrypt
    run_op(2'b00, 0, 0, 0, lat);
    chk("lat128", lat, 12);
    chk("enc128_idx0", 32'(idx_log[0]), 0);
    chk("enc128_idx1", 32'(idx_log[1]), 1);
    chk("enc128_idx9", 32'(idx_log[9]), 9);
    chk("enc128_idx_final", 32'(idx_log[10]), 10);
    chk("enc128_ksel_round1", 32'(ksel_log[1]), 0);

    // AES-256 decrypt
    run_op(2'b10, 1, 0, 0, lat);
    chk("lat256", lat, 16);
    chk("dec256_idx_init", 32'(idx_log[0]), 14);
    chk("dec256_idx_r1", 32'(idx_log[1]), 13);
    chk("dec256_idx_r13", 32'(idx_log[13]), 1);
    chk("dec256_idx_final", 32'(idx_log[14]), 0);
    chk("dec256_ksel_init", 32'(ksel_log[0]), 1);
    chk("dec256_ksel_r1", 32'(ksel_log[1]), 1);
    chk("dec256_ksel_r2", 32'(ksel_log[2]), 0);

    // AES-192 encrypt with a 3-cycle stall at round 5
    run_op(2'b01, 0, 5, 0, lat);
    chk("lat192_stall", lat, 17);

    // Back-to-back with start held high throughout
    run_op(2'b00, 0, 0, 1, lat);
    chk("lat_b2b", lat, 12);
    @(negedge clk);
    chk("b2b_ready", 32'(ready), 1);
    @(negedge clk);
    chk("b2b_init_den", 32'(d_en), 1);
    chk("b2b_init_mode", 32'(mode), 3);
    start = 1'b0;
    repeat (16) @(negedge clk);

    // Illegal key length
    key_len = 2'b11; start = 1'b1;
    @(negedge clk); start = 1'b0; key_len = 2'b00;
    chk("illegal_err", 32'(err), 1);
    chk("illegal_ready", 32'(ready), 1);
    chk("illegal_en", 32'({d_en, k_en}), 0);
    @(negedge clk);
    chk("illegal_err_pulse", 32'(err), 0);

    // Asynchronous reset at round 7
    key_len = 2'b00; decrypt = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mode == 2'b00 && round_idx == 4'd7) break;
      @(negedge clk);
    end
    chk("reached_round7", 32'(round_idx), 7);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_vec", 32'(dut_vec), 32'(RST_VEC));
    @(posedge clk); #1 chk("reset_hold_vec", 32'(dut_vec), 32'(RST_VEC));
    @(negedge clk); reset_n = 1'b1;
    run_op(2'b00, 0, 0, 0, lat);
    chk("lat_after_reset", lat, 12);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
